// File: rtl/vreg_group_write_file_pkg.sv
// vreg_group_write_file_pkg: shared codes; VRF_TAIL_AGNOSTIC_EN selects all-ones tail fill
package vreg_group_write_file_pkg;
  localparam logic [2:0] ONE_BYTE = 3'd0;
  localparam logic [2:0] TWO_BYTE = 3'd1;
  localparam logic [2:0] FOUR_BYTE = 3'd2;
  localparam logic [2:0] EIGHT_BYTE = 3'd3;
  localparam logic [1:0] RF_NOP = 2'd0;
  localparam logic [1:0] RF_BUSY = 2'd1;
  localparam logic [1:0] RF_FINISHED = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef VRF_TAIL_AGNOSTIC_EN
  localparam logic TAIL_AGNOSTIC = 1'b1;
`else
  localparam logic TAIL_AGNOSTIC = 1'b0;
`endif
endpackage

// File: rtl/vreg_group_write_file_vreg_elem_merge.sv
// vreg_elem_merge: merges one beat of group data into a register word under vl, mask and tail policy (VRF_TAIL_AGNOSTIC_EN)
module vreg_elem_merge
  import vreg_group_write_file_pkg::*;
#(
  parameter int VLEN = 256
) (
  input  logic [VLEN-1:0] old_data,
  input  logic [VLEN-1:0] new_data,
  input  logic [1:0]      sew,
  input  logic [2:0]      beat,
  input  logic [31:0]     vl,
  input  logic            vm,
  input  logic [VLEN-1:0] mask,
  output logic [VLEN-1:0] merged
);
  localparam int NB = VLEN / 8;
  localparam int MW = $clog2(VLEN);
  for (genvar i = 0; i < NB; i++) begin : g_byte
    logic [31:0] idx;
    logic act, en;
    assign idx = 32'(beat) * (32'(NB) >> sew) + (32'(i) >> sew);
    assign act = idx < vl;
    assign en = act && (vm || ((idx < 32'(VLEN)) && mask[idx[MW-1:0]]));
    assign merged[i*8 +: 8] = en ? new_data[i*8 +: 8] : (!act && TAIL_AGNOSTIC) ? 8'hFF : old_data[i*8 +: 8];
  end
endmodule

// File: rtl/vreg_group_write_file.sv
// vreg_group_write_file: vector register file with multi-beat register-group writes; tail policy set by VRF_TAIL_AGNOSTIC_EN
module vreg_group_write_file
  import vreg_group_write_file_pkg::*;
#(
  parameter int VLEN = 256,
  parameter int NUM_REGS = 32,
  parameter int MAX_LMUL = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy_in,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [4:0]               rs3,
  output logic [VLEN-1:0]          rs1_data,
  output logic [VLEN-1:0]          rs2_data,
  output logic [VLEN-1:0]          rs3_data,
  output logic [VLEN-1:0]          v0_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [4:0]               rd,
  input  logic [1:0]               lmul,
  input  logic [2:0]               data_type,
  input  logic [31:0]              vl,
  input  logic                     vm,
  input  logic [MAX_LMUL*VLEN-1:0] wr_data,
  output logic [1:0]               rf_status,
  output logic                     wr_error
);
  logic [VLEN-1:0] regs_q [NUM_REGS];
  logic [VLEN-1:0] regs_d [NUM_REGS];
  logic [1:0] state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [4:0] rd_q, rd_d;
  logic [1:0] lmul_q, lmul_d;
  logic [1:0] sew_q, sew_d;
  logic [31:0] vl_q, vl_d;
  logic vm_q, vm_d;
  logic [MAX_LMUL*VLEN-1:0] data_q, data_d;
  logic [VLEN-1:0] v0_q, v0_d;
  logic [4:0] rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic wr_error_q, wr_error_d;
  logic [3:0] gsz;
  logic [2:0] last;
  logic bad, accept;
  logic [4:0] wr_idx;
  logic [VLEN-1:0] merged;

  assign gsz = 4'd1 << lmul;
  assign bad = (|(rd & 5'(gsz - 4'd1))) || (32'(rd) + 32'(gsz) > 32'(NUM_REGS)) ||
               (data_type > EIGHT_BYTE) || (32'(gsz) > 32'(MAX_LMUL));
  assign accept = wr_valid && wr_ready && rdy_in;
  assign last = 3'((4'd1 << lmul_q) - 4'd1);
  assign wr_idx = rd_q + 5'(k_q);
  assign wr_ready = state_q == S_IDLE;
  assign rf_status = state_q == S_WRITE ? RF_BUSY : state_q == S_DONE ? RF_FINISHED : RF_NOP;
  assign wr_error = wr_error_q;
  assign rs1_data = regs_q[rs1_q];
  assign rs2_data = regs_q[rs2_q];
  assign rs3_data = regs_q[rs3_q];
  assign v0_data = regs_q[0];

  vreg_elem_merge #(.VLEN(VLEN)) u_merge (
    .old_data(regs_q[wr_idx]),
    .new_data(data_q[32'(k_q)*VLEN +: VLEN]),
    .sew(sew_q),
    .beat(k_q),
    .vl(vl_q),
    .vm(vm_q),
    .mask(v0_q),
    .merged(merged)
  );

  // next state: capture requests, sequence beats and merge one register per beat; all frozen while rdy_in is low
  always_comb begin
    regs_d = regs_q;
    state_d = state_q;
    k_d = k_q;
    rd_d = rd_q;
    lmul_d = lmul_q;
    sew_d = sew_q;
    vl_d = vl_q;
    vm_d = vm_q;
    data_d = data_q;
    v0_d = v0_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    rs3_d = rs3_q;
    wr_error_d = wr_error_q;
    if (rdy_in) begin
      rs1_d = rs1;
      rs2_d = rs2;
      rs3_d = rs3;
      wr_error_d = accept && bad;
      if (accept && !bad) begin
        rd_d = rd;
        lmul_d = lmul;
        sew_d = data_type[1:0];
        vl_d = vl;
        vm_d = vm;
        data_d = wr_data;
        v0_d = regs_q[0];
        k_d = 3'd0;
        state_d = S_WRITE;
      end
      if (state_q == S_WRITE) begin
        regs_d[wr_idx] = merged;
        k_d = k_q == last ? 3'd0 : k_q + 3'd1;
        state_d = k_q == last ? S_DONE : S_WRITE;
      end
      if (state_q == S_DONE) state_d = S_IDLE;
    end
  end

  // state registers; reset clears the whole file and aborts any group in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      state_q <= S_IDLE;
      k_q <= '0;
      rd_q <= '0;
      lmul_q <= '0;
      sew_q <= '0;
      vl_q <= '0;
      vm_q <= 1'b0;
      data_q <= '0;
      v0_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rs3_q <= '0;
      wr_error_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      state_q <= state_d;
      k_q <= k_d;
      rd_q <= rd_d;
      lmul_q <= lmul_d;
      sew_q <= sew_d;
      vl_q <= vl_d;
      vm_q <= vm_d;
      data_q <= data_d;
      v0_q <= v0_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      rs3_q <= rs3_d;
      wr_error_q <= wr_error_d;
    end
  end
endmodule

// File: tb/tb_vreg_group_write_file.sv
// tb_vreg_group_write_file: randomized and directed checks of group writes against a byte-level reference model
module tb_vreg_group_write_file;
  import vreg_group_write_file_pkg::*;
  localparam int VLEN = 256;
  localparam int GW = 8 * VLEN;
  localparam int NBR = VLEN / 8;
`ifdef VRF_TAIL_AGNOSTIC_EN
  localparam bit TA = 1'b1;
`else
  localparam bit TA = 1'b0;
`endif
  logic clk = 0, rst, rdy_in;
  logic [4:0] rs1, rs2, rs3, rd;
  logic [VLEN-1:0] rs1_data, rs2_data, rs3_data, v0_data;
  logic wr_valid, wr_ready, vm, wr_error;
  logic [1:0] lmul, rf_status;
  logic [2:0] data_type;
  logic [31:0] vl;
  logic [GW-1:0] wr_data;
  logic [VLEN-1:0] model [32];
  logic [VLEN-1:0] rb [32];
  int checks = 0, errors = 0, cyc = 0;

  vreg_group_write_file dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data), .v0_data(v0_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd(rd), .lmul(lmul), .data_type(data_type),
    .vl(vl), .vm(vm), .wr_data(wr_data), .rf_status(rf_status), .wr_error(wr_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [GW-1:0] rand_data();
    logic [GW-1:0] d;
    for (int i = 0; i < GW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic apply_model(input int rd_i, input int lmul_i, input int sew_i, input logic [31:0] vl_i,
                             input logic vm_i, input logic [GW-1:0] d);
    int sb, cap, pos;
    logic [VLEN-1:0] v0s;
    logic act;
    sb = 1 << sew_i;
    cap = (1 << lmul_i) * NBR / sb;
    v0s = model[0];
    for (int g = 0; g < cap; g++) begin
      act = 32'(g) < vl_i;
      for (int b = 0; b < sb; b++) begin
        pos = g * sb + b;
        if (act && (vm_i || v0s[g])) model[rd_i + pos / NBR][(pos % NBR) * 8 +: 8] = d[pos*8 +: 8];
        else if (!act && TA) model[rd_i + pos / NBR][(pos % NBR) * 8 +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic send(input int rd_i, input int lmul_i, input int sew_i, input logic [31:0] vl_i,
                      input logic vm_i, input logic [GW-1:0] d);
    wr_valid = 1; rd = 5'(rd_i); lmul = 2'(lmul_i); data_type = 3'(sew_i);
    vl = vl_i; vm = vm_i; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (rf_status == RF_BUSY && n < 64) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic readback();
    for (int i = 0; i < 32; i += 3) begin
      rs1 = 5'(i); rs2 = 5'((i + 1) % 32); rs3 = 5'((i + 2) % 32);
      @(posedge clk); #1;
      rb[i] = rs1_data; rb[(i + 1) % 32] = rs2_data; rb[(i + 2) % 32] = rs3_data;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rf_status !== RF_NOP) begin errors++; $display("FAIL reset_status got %0d want %0d", rf_status, RF_NOP); end
    checks++; if (wr_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", wr_error); end
    checks++; if (rs1_data !== '0) begin errors++; $display("FAIL reset_rs1 got %h want 0", rs1_data); end
    checks++; if (v0_data !== '0) begin errors++; $display("FAIL reset_v0 got %h want 0", v0_data); end
    rst = 0;
    @(posedge clk); #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", wr_ready); end
  endtask

  task automatic test_single();
    int n;
    logic [GW-1:0] d;
    d = {256{8'h11}};
    send(3, 0, 2, 8, 1, d);
    wait_done(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL single_busy got %0d want 1", n); end
    checks++; if (rf_status !== RF_FINISHED) begin errors++; $display("FAIL single_fin got %0d want %0d", rf_status, RF_FINISHED); end
    apply_model(3, 0, 2, 8, 1, d);
    @(posedge clk); #1;
    checks++; if (rf_status !== RF_NOP || wr_ready !== 1'b1) begin errors++; $display("FAIL single_idle got %0d/%b want %0d/1", rf_status, wr_ready, RF_NOP); end
    readback();
    checks++; if (rb[3] !== {32{8'h11}}) begin errors++; $display("FAIL single_v3 got %h want %h", rb[3], {32{8'h11}}); end
    for (int r = 0; r < 32; r++) begin
      checks++; if (rb[r] !== model[r]) begin errors++; $display("FAIL single_reg%0d got %h want %h", r, rb[r], model[r]); end
    end
  endtask

  task automatic test_tail();
    int n;
    logic [GW-1:0] d;
    d = rand_data();
    send(8, 2, 0, 70, 1, d);
    wait_done(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL tail_busy got %0d want 4", n); end
    apply_model(8, 2, 0, 70, 1, d);
    @(posedge clk); #1;
    readback();
    for (int r = 0; r < 32; r++) begin
      checks++; if (rb[r] !== model[r]) begin errors++; $display("FAIL tail_reg%0d got %h want %h", r, rb[r], model[r]); end
    end
  endtask

  task automatic test_mask();
    int n;
    logic [GW-1:0] d;
    d = '0;
    d[7:0] = 8'h05;
    send(0, 0, 0, 32, 1, d);
    wait_done(n);
    apply_model(0, 0, 0, 32, 1, d);
    @(posedge clk); #1;
    checks++; if (v0_data !== model[0]) begin errors++; $display("FAIL mask_v0 got %h want %h", v0_data, model[0]); end
    d = rand_data();
    send(4, 0, 3, 4, 0, d);
    wait_done(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL mask_busy got %0d want 1", n); end
    apply_model(4, 0, 3, 4, 0, d);
    @(posedge clk); #1;
    readback();
    checks++; if (rb[4][127:64] !== 64'h0) begin errors++; $display("FAIL mask_elem1 got %h want 0", rb[4][127:64]); end
    for (int r = 0; r < 32; r++) begin
      checks++; if (rb[r] !== model[r]) begin errors++; $display("FAIL mask_reg%0d got %h want %h", r, rb[r], model[r]); end
    end
  endtask

  task automatic test_error();
    send(5, 1, 2, 8, 1, rand_data());
    checks++; if (wr_error !== 1'b1) begin errors++; $display("FAIL err_align got %b want 1", wr_error); end
    checks++; if (rf_status !== RF_NOP || wr_ready !== 1'b1) begin errors++; $display("FAIL err_idle got %0d/%b want %0d/1", rf_status, wr_ready, RF_NOP); end
    @(posedge clk); #1;
    checks++; if (wr_error !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", wr_error); end
    send(2, 0, 5, 8, 1, rand_data());
    checks++; if (wr_error !== 1'b1) begin errors++; $display("FAIL err_sew got %b want 1", wr_error); end
    @(posedge clk); #1;
    readback();
    for (int r = 0; r < 32; r++) begin
      checks++; if (rb[r] !== model[r]) begin errors++; $display("FAIL err_reg%0d got %h want %h", r, rb[r], model[r]); end
    end
  endtask

  task automatic test_stall();
    int n, c0;
    logic [GW-1:0] d;
    d = rand_data();
    rs1 = 5'd9;
    send(16, 3, 1, 32'hFFFF, 1, d);
    c0 = cyc;
    @(posedge clk); #1;
    rdy_in = 0;
    rs1 = 5'd31;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (rf_status !== RF_BUSY) begin errors++; $display("FAIL stall_status got %0d want %0d", rf_status, RF_BUSY); end
      checks++; if (rs1_data !== model[9]) begin errors++; $display("FAIL stall_rs1 got %h want %h", rs1_data, model[9]); end
    end
    rdy_in = 1;
    wait_done(n);
    checks++; if (cyc - c0 !== 11) begin errors++; $display("FAIL stall_latency got %0d want 11", cyc - c0); end
    checks++; if (rf_status !== RF_FINISHED) begin errors++; $display("FAIL stall_fin got %0d want %0d", rf_status, RF_FINISHED); end
    apply_model(16, 3, 1, 32'hFFFF, 1, d);
    @(posedge clk); #1;
    readback();
    for (int r = 0; r < 32; r++) begin
      checks++; if (rb[r] !== model[r]) begin errors++; $display("FAIL stall_reg%0d got %h want %h", r, rb[r], model[r]); end
    end
  endtask

  task automatic test_random();
    int n, lm, gs, rdi, sew, cap;
    logic [31:0] vli;
    logic vmi, ok;
    logic [GW-1:0] d;
    for (int it = 0; it < 40; it++) begin
      lm = $urandom % 4;
      gs = 1 << lm;
      rdi = $urandom % 32;
      if ($urandom % 4 != 0) rdi = rdi & ~(gs - 1);
      sew = ($urandom % 8 == 0) ? 4 + $urandom % 4 : $urandom % 4;
      ok = (rdi % gs == 0) && sew < 4;
      cap = ok ? gs * NBR / (1 << sew) : 1;
      case ($urandom % 4)
        0: vli = 0;
        1: vli = 32'($urandom % (cap + 1));
        2: vli = 32'(cap + $urandom % 16);
        default: vli = $urandom;
      endcase
      vmi = 1'($urandom % 2);
      d = rand_data();
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rand_ready it%0d got %b want 1", it, wr_ready); end
      send(rdi, lm, sew, vli, vmi, d);
      if (ok) begin
        wait_done(n);
        checks++; if (n !== gs) begin errors++; $display("FAIL rand_busy it%0d got %0d want %0d", it, n, gs); end
        checks++; if (rf_status !== RF_FINISHED) begin errors++; $display("FAIL rand_fin it%0d got %0d want %0d", it, rf_status, RF_FINISHED); end
        apply_model(rdi, lm, sew, vli, vmi, d);
      end else begin
        checks++; if (wr_error !== 1'b1) begin errors++; $display("FAIL rand_err it%0d got %b want 1", it, wr_error); end
      end
      @(posedge clk); #1;
      checks++; if (wr_error !== 1'b0) begin errors++; $display("FAIL rand_errclr it%0d got %b want 0", it, wr_error); end
      readback();
      for (int r = 0; r < 32; r++) begin
        checks++; if (rb[r] !== model[r]) begin errors++; $display("FAIL rand_reg%0d it%0d got %h want %h", r, it, rb[r], model[r]); end
      end
    end
  endtask

  task automatic test_reset_abort();
    send(24, 3, 0, 32'hFFFF_FFFF, 1, rand_data());
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++; if (rf_status !== RF_NOP || wr_ready !== 1'b1) begin errors++; $display("FAIL abort_idle got %0d/%b want %0d/1", rf_status, wr_ready, RF_NOP); end
    for (int r = 0; r < 32; r++) model[r] = '0;
    readback();
    for (int r = 0; r < 32; r++) begin
      checks++; if (rb[r] !== model[r]) begin errors++; $display("FAIL abort_reg%0d got %h want %h", r, rb[r], model[r]); end
    end
  endtask

  initial begin
    rst = 1; rdy_in = 1; wr_valid = 0; rs1 = 0; rs2 = 0; rs3 = 0;
    rd = 0; lmul = 0; data_type = 0; vl = 0; vm = 0; wr_data = '0;
    for (int r = 0; r < 32; r++) model[r] = '0;
    test_reset();
    test_single();
    test_tail();
    test_mask();
    test_error();
    test_stall();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
